snake_move_scheduler: RTL and testbench

Paces the snake game and decides each move's direction. It takes one-cycle direction requests from the key-input stage and rejects reversals and repeats. Accepted turns are buffered in a 2-entry queue, so quick double-taps are not lost. On every game tick it issues one step command, with a valid/ready handshake, to the snake body/draw engine. It also owns the game-state FSM (idle, run, wait, over).

---
 rtl/snake_pkg.sv | 24 ++
 rtl/snake_dir_queue.sv | 66 ++++++
 rtl/snake_move_scheduler.sv | 168 ++++++++++++++++
 tb/tb_snake_move_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake move scheduler: direction codes, game-state
// encoding and the reversal helper.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_LEFT  = 2'b01;
    localparam dir_t DIR_RIGHT = 2'b10;
    localparam dir_t DIR_DOWN  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        WAIT = 2'b10,
        OVER = 2'b11
    } state_t;

    // Opposite directions are bitwise inverses of each other.
    function automatic dir_t opposite(input dir_t d);
        return ~d;
    endfunction

endpackage

// File: rtl/snake_dir_queue.sv
// Two-entry turn queue with the reversal/repeat filter applied on entry.
module snake_dir_queue
    import snake_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_valid,
    input  dir_t i_req_dir,
    input  logic i_pop,
    input  dir_t i_cur_dir,
    output dir_t o_head,
    output dir_t o_tail,
    output logic o_empty,
    output logic o_full,
    output logic o_push
);

    dir_t       r_q0;
    dir_t       r_q1;
    logic [1:0] r_count;
    logic       w_pop;
    dir_t       w_ref;

    assign o_empty = (r_count == 2'd0);
    assign o_full  = (r_count == 2'd2);
    assign o_head  = r_q0;
    assign o_tail  = o_full ? r_q1 : r_q0;
    assign w_pop   = i_pop && !o_empty;

    // Post-pop tail, or the just-committed head when a pop empties the queue,
    // is always the current tail; only an empty queue falls back to cur_dir.
    assign w_ref  = o_empty ? i_cur_dir : o_tail;
    assign o_push = i_req_valid && (i_req_dir != w_ref) &&
                    (i_req_dir != opposite(w_ref)) && (!o_full || w_pop);

    // Queue storage and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q0    <= DIR_RIGHT;
            r_q1    <= DIR_RIGHT;
            r_count <= 2'd0;
        end else begin
            case ({w_pop, o_push})
                2'b10: begin
                    r_q0    <= r_q1;
                    r_count <= r_count - 2'd1;
                end
                2'b01: begin
                    if (o_empty) r_q0 <= i_req_dir;
                    else         r_q1 <= i_req_dir;
                    r_count <= r_count + 2'd1;
                end
                2'b11: begin
                    if (o_full) begin
                        r_q0 <= r_q1;
                        r_q1 <= i_req_dir;
                    end else begin
                        r_q0 <= i_req_dir;
                    end
                end
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/snake_move_scheduler.sv
// Snake move pacing: tick counter, game FSM and step handshake.
// Define SNAKE_SPEEDUP_EN to let food_eaten shorten the tick period.
module snake_move_scheduler
    import snake_pkg::*;
#(
    parameter int TICK_DIV  = 12_500_000,
    parameter int TICK_STEP = 500_000,
    parameter int TICK_MIN  = 2_500_000,
    parameter int CNT_W     = 26
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       dir_req_valid,
    input  logic [1:0] dir_req,
    input  logic       pause,
    input  logic       step_ready,
    input  logic       collision,
    input  logic       food_eaten,
    output logic       step_valid,
    output logic [1:0] step_dir,
    output logic [1:0] cur_dir,
    output logic       game_over,
    output logic [1:0] fsm_state
);

    localparam logic [CNT_W-1:0] P_DIV = CNT_W'(TICK_DIV);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic             r_step_valid;
    logic             r_game_over;
    dir_t             r_step_dir;
    dir_t             r_cur_dir;
    logic [CNT_W-1:0] w_period;
    dir_t             w_head;
    dir_t             w_unused_tail;
    logic             w_empty;
    logic             w_unused_full;
    logic             w_push;
    logic             w_active;
    logic             w_cnt_en;
    logic             w_wrap;
    logic             w_fire;
    logic             w_kill;
    logic             w_req_en;

    assign w_active = (r_state == RUN) || (r_state == WAIT);
    assign w_kill   = w_active && collision;
    assign w_cnt_en = ((r_state == RUN) && !pause) || (r_state == WAIT);
    assign w_wrap   = w_cnt_en && (r_cnt == (w_period - CNT_W'(1)));
    assign w_fire   = (r_state == RUN) && !collision && (w_wrap || r_pending);
    assign w_req_en = dir_req_valid && (r_state != OVER) && !w_kill;

`ifdef SNAKE_SPEEDUP_EN
    localparam logic [CNT_W-1:0] P_STEP = CNT_W'(TICK_STEP);
    localparam logic [CNT_W-1:0] P_MIN  = CNT_W'(TICK_MIN);

    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_period_next;

    // Food shortens the staged period; the counter only adopts it on a wrap.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_period      <= P_DIV;
            r_period_next <= P_DIV;
        end else begin
            if (w_active && food_eaten && !collision) begin
                r_period_next <= (r_period_next >= (P_MIN + P_STEP)) ?
                                 (r_period_next - P_STEP) : P_MIN;
            end else begin
                r_period_next <= r_period_next;
            end
            if (w_wrap) r_period <= r_period_next;
            else        r_period <= r_period;
        end
    end

    assign w_period = r_period;
`else
    localparam int unused_speedup_params = TICK_STEP + TICK_MIN;
    logic w_unused_food;

    assign w_unused_food = food_eaten;
    assign w_period      = P_DIV;
`endif

    snake_dir_queue u_queue (
        .clk         (CLOCK_50),
        .rst_n       (resetn),
        .i_req_valid (w_req_en),
        .i_req_dir   (dir_req),
        .i_pop       (w_fire),
        .i_cur_dir   (r_cur_dir),
        .o_head      (w_head),
        .o_tail      (w_unused_tail),
        .o_empty     (w_empty),
        .o_full      (w_unused_full),
        .o_push      (w_push)
    );

    // Game FSM, tick counter, pending-tick flag and step handshake.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_cnt        <= {CNT_W{1'b0}};
            r_pending    <= 1'b0;
            r_step_valid <= 1'b0;
            r_game_over  <= 1'b0;
            r_step_dir   <= DIR_RIGHT;
            r_cur_dir    <= DIR_RIGHT;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= {CNT_W{1'b0}};
                    if (w_push) r_state <= RUN;
                end
                RUN: begin
                    if (collision) begin
                        r_state      <= OVER;
                        r_step_valid <= 1'b0;
                        r_game_over  <= 1'b1;
                    end else begin
                        if (w_cnt_en) r_cnt <= w_wrap ? {CNT_W{1'b0}} : (r_cnt + CNT_W'(1));
                        if (w_fire) begin
                            r_pending    <= 1'b0;
                            r_step_valid <= 1'b1;
                            r_state      <= WAIT;
                            if (!w_empty) begin
                                r_cur_dir  <= w_head;
                                r_step_dir <= w_head;
                            end else begin
                                r_step_dir <= r_cur_dir;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (collision) begin
                        r_state      <= OVER;
                        r_step_valid <= 1'b0;
                        r_game_over  <= 1'b1;
                    end else begin
                        r_cnt <= w_wrap ? {CNT_W{1'b0}} : (r_cnt + CNT_W'(1));
                        // Only one missed tick is remembered while stalled.
                        if (w_wrap) r_pending <= 1'b1;
                        if (step_ready) begin
                            r_step_valid <= 1'b0;
                            r_state      <= RUN;
                        end
                    end
                end
                OVER: begin
                    r_step_valid <= 1'b0;
                    r_game_over  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign step_valid = r_step_valid;
    assign step_dir   = r_step_dir;
    assign cur_dir    = r_cur_dir;
    assign game_over  = r_game_over;
    assign fsm_state  = r_state;

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Scoreboard bench for snake_move_scheduler with TICK_DIV=4.
module tb_snake_move_scheduler;

    logic       clk;
    logic       resetn;
    logic       dir_req_valid;
    logic [1:0] dir_req;
    logic       pause;
    logic       step_ready;
    logic       collision;
    logic       food_eaten;
    logic       step_valid;
    logic [1:0] step_dir;
    logic [1:0] cur_dir;
    logic       game_over;
    logic [1:0] fsm_state;

    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    int         hs_count = 0;
    int         hs_last  = 0;
    int         hs_gap   = 0;
    logic [1:0] exp_cur  = 2'b10;
    logic [1:0] sb[$];

    snake_move_scheduler #(
        .TICK_DIV  (4),
        .TICK_STEP (1),
        .TICK_MIN  (2),
        .CNT_W     (8)
    ) dut (
        .CLOCK_50      (clk),
        .resetn        (resetn),
        .dir_req_valid (dir_req_valid),
        .dir_req       (dir_req),
        .pause         (pause),
        .step_ready    (step_ready),
        .collision     (collision),
        .food_eaten    (food_eaten),
        .step_valid    (step_valid),
        .step_dir      (step_dir),
        .cur_dir       (cur_dir),
        .game_over     (game_over),
        .fsm_state     (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Each accepted step pops the next queued turn; with none queued the
    // snake keeps its last direction.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && step_valid && step_ready) begin
                hs_count++;
                hs_gap  = cyc - hs_last;
                hs_last = cyc;
                if (sb.size() > 0) exp_cur = sb.pop_front();
                checks++;
                if (step_dir !== exp_cur) begin
                    errors++;
                    $display("FAIL step_dir #%0d: got %b expected %b", hs_count, step_dir, exp_cur);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [1:0] d);
        dir_req_valid = 1'b1;
        dir_req       = d;
        tick();
        dir_req_valid = 1'b0;
    endtask

    task automatic wait_hs(input string name);
        int  start;
        bit  seen;
        start = hs_count;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (hs_count != start) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: handshakes got 0 expected 1 within 40 cycles", name);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        checks++;
        if (step_valid !== 1'b0 || fsm_state !== 2'b00) begin
            errors++;
            $display("FAIL in_reset: got valid=%b state=%b expected 0/00", step_valid, fsm_state);
        end
        resetn = 1'b1;
        repeat (20) tick();
        checks++;
        if (fsm_state !== 2'b00) begin errors++; $display("FAIL idle_state: got %b expected 00", fsm_state); end
        checks++;
        if (step_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", step_valid); end
        checks++;
        if (cur_dir !== 2'b10) begin errors++; $display("FAIL reset_cur_dir: got %b expected 10", cur_dir); end
        checks++;
        if (step_dir !== 2'b10) begin errors++; $display("FAIL reset_step_dir: got %b expected 10", step_dir); end
        checks++;
        if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b expected 0", game_over); end
        collision = 1'b1;
        tick();
        collision = 1'b0;
        tick();
        checks++;
        if (fsm_state !== 2'b00 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL idle_collision: got state=%b over=%b expected 00/0", fsm_state, game_over);
        end
        send_req(2'b01);
        send_req(2'b10);
        tick();
        checks++;
        if (fsm_state !== 2'b00) begin errors++; $display("FAIL idle_filter: got %b expected 00", fsm_state); end
    endtask

    task automatic test_single_dir();
        step_ready = 1'b1;
        sb.push_back(2'b00);
        send_req(2'b00);
        checks++;
        if (fsm_state !== 2'b01) begin errors++; $display("FAIL enter_run: got %b expected 01", fsm_state); end
        wait_hs("single_first");
        for (int k = 0; k < 3; k++) begin
            wait_hs("single_next");
            checks++;
            if (hs_gap !== 4) begin errors++; $display("FAIL single_period: got %0d expected 4", hs_gap); end
        end
        checks++;
        if (cur_dir !== 2'b00) begin errors++; $display("FAIL single_cur_dir: got %b expected 00", cur_dir); end
    endtask

    task automatic test_filter();
        int h0;
        wait_hs("filter_sync");
        sb.push_back(2'b01);
        sb.push_back(2'b00);
        pause = 1'b1;
        h0 = hs_count;
        send_req(2'b11);
        send_req(2'b01);
        send_req(2'b01);
        send_req(2'b10);
        send_req(2'b00);
        repeat (4) tick();
        checks++;
        if (hs_count !== h0) begin errors++; $display("FAIL pause_freeze: got %0d steps expected 0", hs_count - h0); end
        pause = 1'b0;
        wait_hs("filter_step1");
        wait_hs("filter_step2");
        checks++;
        if (cur_dir !== 2'b00) begin errors++; $display("FAIL filter_cur_dir: got %b expected 00", cur_dir); end
    endtask

    task automatic test_double_tap();
        wait_hs("tap_sync");
        sb.push_back(2'b01);
        sb.push_back(2'b11);
        sb.push_back(2'b01);
        pause = 1'b1;
        send_req(2'b01);
        send_req(2'b11);
        send_req(2'b10);
        pause = 1'b0;
        tick();
        tick();
        send_req(2'b01);
        wait_hs("tap_step1");
        wait_hs("tap_step2");
        checks++;
        if (hs_gap !== 4) begin errors++; $display("FAIL tap_period: got %0d expected 4", hs_gap); end
        wait_hs("tap_step3");
        checks++;
        if (cur_dir !== 2'b01) begin errors++; $display("FAIL tap_cur_dir: got %b expected 01", cur_dir); end
    endtask

    task automatic test_backpressure();
        int n;
        wait_hs("bp_sync");
        step_ready = 1'b0;
        n = 0;
        while (!step_valid && n < 20) begin tick(); n++; end
        checks++;
        if (step_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_rise: got %b expected 1", step_valid); end
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (step_valid !== 1'b1 || step_dir !== 2'b01 || fsm_state !== 2'b10) begin
                errors++;
                $display("FAIL bp_hold: got valid=%b dir=%b state=%b expected 1/01/10", step_valid, step_dir, fsm_state);
            end
        end
        step_ready = 1'b1;
        wait_hs("bp_ack");
        wait_hs("bp_extra");
        checks++;
        if (hs_gap !== 2) begin errors++; $display("FAIL bp_extra_gap: got %0d expected 2", hs_gap); end
        wait_hs("bp_regular");
        checks++;
        if (hs_gap !== 4) begin errors++; $display("FAIL bp_regular_gap: got %0d expected 4", hs_gap); end
    endtask

    task automatic test_collision();
        int n;
        int h0;
        step_ready = 1'b0;
        n = 0;
        while (!step_valid && n < 20) begin tick(); n++; end
        checks++;
        if (fsm_state !== 2'b10) begin errors++; $display("FAIL col_wait: got %b expected 10", fsm_state); end
        collision     = 1'b1;
        dir_req_valid = 1'b1;
        dir_req       = 2'b00;
        tick();
        collision     = 1'b0;
        dir_req_valid = 1'b0;
        checks++;
        if (step_valid !== 1'b0 || game_over !== 1'b1 || fsm_state !== 2'b11) begin
            errors++;
            $display("FAIL col_over: got valid=%b over=%b state=%b expected 0/1/11", step_valid, game_over, fsm_state);
        end
        step_ready = 1'b1;
        h0 = hs_count;
        for (int k = 0; k < 20; k++) begin
            pause = k[0];
            send_req(k[2:1]);
        end
        pause = 1'b0;
        checks++;
        if (hs_count !== h0 || fsm_state !== 2'b11 || game_over !== 1'b1 || cur_dir !== 2'b01 || step_valid !== 1'b0) begin
            errors++;
            $display("FAIL over_ignore: got steps=%0d state=%b over=%b dir=%b valid=%b expected 0/11/1/01/0",
                     hs_count - h0, fsm_state, game_over, cur_dir, step_valid);
        end
    endtask

    task automatic test_async_reset();
        int n;
        resetn = 1'b0;
        #1;
        checks++;
        if (fsm_state !== 2'b00 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL over_reset: got state=%b over=%b expected 00/0", fsm_state, game_over);
        end
        resetn = 1'b1;
        sb.delete();
        exp_cur    = 2'b10;
        step_ready = 1'b0;
        tick();
        send_req(2'b00);
        n = 0;
        while (!step_valid && n < 20) begin tick(); n++; end
        checks++;
        if (step_valid !== 1'b1 || step_dir !== 2'b00) begin
            errors++;
            $display("FAIL ar_valid: got valid=%b dir=%b expected 1/00", step_valid, step_dir);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (step_valid !== 1'b0 || step_dir !== 2'b10 || cur_dir !== 2'b10 || fsm_state !== 2'b00) begin
            errors++;
            $display("FAIL async_drop: got valid=%b dir=%b cur=%b state=%b expected 0/10/10/00",
                     step_valid, step_dir, cur_dir, fsm_state);
        end
        tick();
        resetn = 1'b1;
        tick();
    endtask

`ifdef SNAKE_SPEEDUP_EN
    task automatic test_speedup();
        int p_old;
        int p_new;
        step_ready = 1'b1;
        sb.push_back(2'b00);
        send_req(2'b00);
        wait_hs("spd_first");
        p_old = 4;
        for (int k = 0; k < 3; k++) begin
            food_eaten = 1'b1;
            tick();
            food_eaten = 1'b0;
            p_new = (p_old - 1 > 2) ? p_old - 1 : 2;
            wait_hs("spd_old");
            checks++;
            if (hs_gap !== p_old) begin errors++; $display("FAIL spd_old_gap: got %0d expected %0d", hs_gap, p_old); end
            wait_hs("spd_new");
            checks++;
            if (hs_gap !== p_new) begin errors++; $display("FAIL spd_new_gap: got %0d expected %0d", hs_gap, p_new); end
            p_old = p_new;
        end
    endtask
`endif

    initial begin
        resetn        = 1'b0;
        dir_req_valid = 1'b0;
        dir_req       = 2'b00;
        pause         = 1'b0;
        step_ready    = 1'b0;
        collision     = 1'b0;
        food_eaten    = 1'b0;
        test_reset();
        test_single_dir();
        test_filter();
        test_double_tap();
        test_backpressure();
        test_collision();
        test_async_reset();
`ifdef SNAKE_SPEEDUP_EN
        test_speedup();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
